io_port_bank: RTL and testbench

- Parametrised memory-mapped I/O block replacing the single direct io_read_device/io_write_device path of the 16-bit RISC core.
- Provides N_IN debounced input channels and N_OUT latched output channels, each DATA_W wide.
- Adds per-channel change detection with maskable, level-sensitive interrupt.
- Sits between the datapath load/store path and the board switches/LEDs.

---
 rtl/io_port_pkg.sv | 22 ++
 rtl/io_debounce.sv | 72 +++++++
 rtl/io_port_bank.sv | 131 +++++++++++++
 tb/tb_io_port_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// io_port_pkg
// Shared constants for the memory-mapped I/O port bank: register map
// addresses, the channel-count ceiling and a helper sizing the debounce
// counter. Imported by io_debounce and io_port_bank.
package io_port_pkg;

  // Register map (4-bit bus address)
  localparam logic [3:0] ADDR_IN_BASE  = 4'h0;
  localparam logic [3:0] ADDR_OUT_BASE = 4'h4;
  localparam logic [3:0] ADDR_STATUS   = 4'h8;
  localparam logic [3:0] ADDR_MASK     = 4'h9;

  // The map reserves four slots for each of IN_k and OUT_k
  localparam int MAX_CH = 4;

  // Counter must hold DEBOUNCE_CYCLES-1; one spare bit keeps the
  // DEBOUNCE_CYCLES=1 case at a legal non-zero width.
  function automatic int dbc_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce
// One input channel: two-flop synchroniser on every bit followed by a
// channel-wide debounce filter. A new value is accepted only once the
// synchronised input has differed from the accepted value for
// DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   din      in   raw asynchronous device input, DATA_W bits
//   stable   out  debounced (accepted) value
//   changed  out  high in the cycle whose rising edge loads a new stable
module io_debounce
  import io_port_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] stable,
  output logic              changed
);

  localparam int              CNT_W   = dbc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] s2_q, s2_d;
  logic [DATA_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  // Any cycle where s2 matches stable restarts the count, so a glitch
  // has to persist for the full window before it is believed.
  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        accept   = 1'b1;
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable  = stable_q;
  // accept only fires when s2 differs from stable, so every pulse marks
  // a real change of value.
  assign changed = accept;

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank
// Memory-mapped I/O block between the core's load/store path and the
// board switches/LEDs. N_IN debounced input channels, N_OUT latched
// output channels, per-input change flags (STATUS, write-1-to-clear)
// and a maskable level interrupt.
//
// Register map: 0x0-0x3 IN_k (RO), 0x4-0x7 OUT_k (RW),
//               0x8 STATUS (W1C), 0x9 MASK (RW). Others read 0.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   bus_addr    in   register address
//   bus_wdata   in   write data
//   bus_we      in   single-cycle write strobe
//   bus_re      in   single-cycle read strobe
//   bus_rdata   out  registered read data
//   bus_rvalid  out  registered read-valid, the cycle after bus_re
//   in_dev      in   raw device inputs, channel k at [k*DATA_W +: DATA_W]
//   out_dev     out  output channel registers, same packing
//   irq         out  registered |(STATUS & MASK)
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int                DATA_W          = 16,
  parameter int                N_IN            = 2,
  parameter int                N_OUT           = 2,
  parameter int                DEBOUNCE_CYCLES = 4,
  parameter logic [DATA_W-1:0] OUT_RESET       = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              bus_addr,
  input  logic [DATA_W-1:0]       bus_wdata,
  input  logic                    bus_we,
  input  logic                    bus_re,
  output logic [DATA_W-1:0]       bus_rdata,
  output logic                    bus_rvalid,
  input  logic [N_IN*DATA_W-1:0]  in_dev,
  output logic [N_OUT*DATA_W-1:0] out_dev,
  output logic                    irq
);

  if (N_IN < 1 || N_IN > MAX_CH || N_OUT < 1 || N_OUT > MAX_CH) begin : g_bad_params
    $error("io_port_bank: N_IN and N_OUT must be in 1..4");
  end

  logic [N_IN-1:0][DATA_W-1:0]  in_stable;
  logic [N_IN-1:0]              in_changed;

  logic [N_OUT-1:0][DATA_W-1:0] out_q, out_d;
  logic [N_IN-1:0]              status_q, status_d;
  logic [N_IN-1:0]              mask_q, mask_d;
  logic [N_IN-1:0]              status_clr;
  logic [DATA_W-1:0]            rdata_q, rdata_d;
  logic [DATA_W-1:0]            rd_mux;
  logic                         rvalid_q, rvalid_d;
  logic                         irq_q, irq_d;

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    io_debounce #(
      .DATA_W          (DATA_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (in_dev[k*DATA_W +: DATA_W]),
      .stable  (in_stable[k]),
      .changed (in_changed[k])
    );
  end

  // Write decode. Writes to IN_k, missing channels and unmapped
  // addresses fall through with nothing updated.
  always_comb begin
    out_d      = out_q;
    mask_d     = mask_q;
    status_clr = '0;
    if (bus_we) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (bus_addr == 4'(ADDR_OUT_BASE + k)) out_d[k] = bus_wdata;
      end
      if (bus_addr == ADDR_STATUS) status_clr = bus_wdata[N_IN-1:0];
      if (bus_addr == ADDR_MASK)   mask_d     = bus_wdata[N_IN-1:0];
    end
    // OR-ing the change pulses in last lets a new change win over a
    // simultaneous write-1-to-clear.
    status_d = (status_q & ~status_clr) | in_changed;
    irq_d    = |(status_q & mask_q);
  end

  // Read mux works on current register values, so a read and write to
  // the same address in one cycle returns the pre-write contents.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (bus_addr == 4'(ADDR_IN_BASE + k)) rd_mux = in_stable[k];
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (bus_addr == 4'(ADDR_OUT_BASE + k)) rd_mux = out_q[k];
    end
    if (bus_addr == ADDR_STATUS) rd_mux[N_IN-1:0] = status_q;
    if (bus_addr == ADDR_MASK)   rd_mux[N_IN-1:0] = mask_q;
    rdata_d  = bus_re ? rd_mux : rdata_q;
    rvalid_d = bus_re;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= {N_OUT{OUT_RESET}};
      status_q <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      status_q <= status_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign out_dev    = out_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank
// Self-checking bench for io_port_bank with OUT_RESET=16'hA5A5, two
// input and two output channels, DEBOUNCE_CYCLES=4. A table of bus
// transactions covers the register map; hand-written sequences cover
// debounce latency, glitch rejection, the interrupt path and
// asynchronous reset.
module tb_io_port_bank;

  localparam int          DATA_W  = 16;
  localparam int          N_IN    = 2;
  localparam int          N_OUT   = 2;
  localparam int          DBC     = 4;
  localparam logic [15:0] OUT_RST = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [15:0] bus_rdata;
  logic        bus_rvalid;
  logic [31:0] in_dev = '0;
  logic [31:0] out_dev;
  logic        irq;

  int checks = 0;
  int errors = 0;

  io_port_bank #(
    .DATA_W          (DATA_W),
    .N_IN            (N_IN),
    .N_OUT           (N_OUT),
    .DEBOUNCE_CYCLES (DBC),
    .OUT_RESET       (OUT_RST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .in_dev     (in_dev),
    .out_dev    (out_dev),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic        we;
    logic [15:0] wdata;
    logic        re;
    logic [15:0] exp_rdata;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One bus cycle: strobes are high across exactly one rising edge.
  task automatic applyStimulus(input logic [3:0] addr, input logic we,
                               input logic [15:0] wdata, input logic re);
    bus_addr  = addr;
    bus_we    = we;
    bus_wdata = wdata;
    bus_re    = re;
    tick();
    bus_we = 1'b0;
    bus_re = 1'b0;
  endtask

  task automatic busRead(input string name, input logic [3:0] addr,
                         input logic [15:0] expected);
    applyStimulus(addr, 1'b0, 16'h0, 1'b1);
    checkOutput({name, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    checkOutput(name, 32'(bus_rdata), 32'(expected));
  endtask

  // Call right after changing in_dev: that change is captured at the
  // next edge e0, stable updates at e0+5 and a held read shows it one
  // edge later.
  task automatic checkLatency(input string name, input logic [3:0] addr,
                              input logic [15:0] old_val, input logic [15:0] new_val);
    bus_addr = addr;
    bus_re   = 1'b1;
    repeat (6) tick();
    checkOutput({name, "_early"}, 32'(bus_rdata), 32'(old_val));
    tick();
    checkOutput({name, "_ontime"}, 32'(bus_rdata), 32'(new_val));
    bus_re = 1'b0;
  endtask

  initial begin
    int          irq_at;
    logic [15:0] last_st;

    vecs[0]  = '{"wr_out1",        4'h5, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 32'hBEEF_A5A5};
    vecs[1]  = '{"rd_out1",        4'h5, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 32'hBEEF_A5A5};
    vecs[2]  = '{"rd_unmapped_c",  4'hC, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'hBEEF_A5A5};
    vecs[3]  = '{"rdwr_out0",      4'h4, 1'b1, 16'h1111, 1'b1, 16'hA5A5, 32'hBEEF_1111};
    vecs[4]  = '{"rd_out0",        4'h4, 1'b0, 16'h0000, 1'b1, 16'h1111, 32'hBEEF_1111};
    vecs[5]  = '{"wr_in0_ignored", 4'h0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 32'hBEEF_1111};
    vecs[6]  = '{"rd_in0",         4'h0, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'hBEEF_1111};
    vecs[7]  = '{"wr_out2_oor",    4'h6, 1'b1, 16'h1234, 1'b0, 16'h0000, 32'hBEEF_1111};
    vecs[8]  = '{"rd_out2_oor",    4'h6, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'hBEEF_1111};
    vecs[9]  = '{"rd_in2_oor",     4'h2, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'hBEEF_1111};
    vecs[10] = '{"wr_mask",        4'h9, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 32'hBEEF_1111};
    vecs[11] = '{"rd_mask",        4'h9, 1'b0, 16'h0000, 1'b1, 16'h0003, 32'hBEEF_1111};
    vecs[12] = '{"wr_mask_zero",   4'h9, 1'b1, 16'h0000, 1'b1, 16'h0003, 32'hBEEF_1111};
    vecs[13] = '{"rd_status",      4'h8, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'hBEEF_1111};

    // Reset values, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_out_dev", out_dev, 32'hA5A5_A5A5);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_rvalid", 32'(bus_rvalid), 32'd0);
    checkOutput("rst_rdata", 32'(bus_rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    busRead("rst_status", 4'h8, 16'h0000);

    // Register map table
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].re);
      checkOutput({vecs[i].name, "_rvalid"}, 32'(bus_rvalid), 32'(vecs[i].re));
      if (vecs[i].re) checkOutput({vecs[i].name, "_rdata"}, 32'(bus_rdata), 32'(vecs[i].exp_rdata));
      checkOutput({vecs[i].name, "_out"}, out_dev, vecs[i].exp_out);
    end
    tick();
    checkOutput("rvalid_drop", 32'(bus_rvalid), 32'd0);
    checkOutput("rdata_hold", 32'(bus_rdata), 32'h0000);
    checkOutput("irq_masked_off", 32'(irq), 32'd0);

    // Input acceptance on ch0
    in_dev[15:0] = 16'h00FF;
    checkLatency("in0_accept", 4'h0, 16'h0000, 16'h00FF);
    busRead("status_ch0", 4'h8, 16'h0001);
    applyStimulus(4'h8, 1'b1, 16'h0001, 1'b0);
    busRead("status_w1c", 4'h8, 16'h0000);

    // Three-cycle glitch on ch1 must be rejected
    in_dev[31:16] = 16'h0001;
    repeat (3) tick();
    in_dev[31:16] = 16'h0000;
    repeat (8) tick();
    busRead("glitch_in1", 4'h1, 16'h0000);
    busRead("glitch_status", 4'h8, 16'h0000);

    // Interrupt path: STATUS visible one edge before irq follows
    applyStimulus(4'h9, 1'b1, 16'h0002, 1'b0);
    in_dev[31:16] = 16'h1234;
    bus_addr = 4'h8;
    bus_re   = 1'b1;
    irq_at   = 0;
    last_st  = 16'hFFFF;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (irq === 1'b1) begin
        irq_at = i;
        break;
      end
      last_st = bus_rdata;
    end
    bus_re = 1'b0;
    checkOutput("irq_latency", 32'(irq_at), 32'd7);
    checkOutput("irq_status_now", 32'(bus_rdata), 32'h0002);
    checkOutput("irq_status_prev", 32'(last_st), 32'h0000);

    applyStimulus(4'h8, 1'b1, 16'h0002, 1'b0);
    checkOutput("irq_after_w1c_edge", 32'(irq), 32'd1);
    tick();
    checkOutput("irq_cleared", 32'(irq), 32'd0);

    // W1C on the very edge a new ch1 value is accepted: set wins
    in_dev[31:16] = 16'h5678;
    repeat (5) tick();
    applyStimulus(4'h8, 1'b1, 16'h0002, 1'b0);
    busRead("set_wins_status", 4'h8, 16'h0002);
    checkOutput("set_wins_irq", 32'(irq), 32'd1);
    busRead("in1_5678", 4'h1, 16'h5678);

    // Async reset mid-debounce and with a read outstanding
    in_dev[15:0] = 16'h0F0F;
    repeat (3) tick();
    bus_addr = 4'h5;
    bus_re   = 1'b1;
    tick();
    checkOutput("pre_rst_rvalid", 32'(bus_rvalid), 32'd1);
    checkOutput("pre_rst_rdata", 32'(bus_rdata), 32'h0000_BEEF);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_rvalid", 32'(bus_rvalid), 32'd0);
    checkOutput("arst_rdata", 32'(bus_rdata), 32'd0);
    checkOutput("arst_irq", 32'(irq), 32'd0);
    checkOutput("arst_out_dev", out_dev, 32'hA5A5_A5A5);
    bus_re        = 1'b0;
    in_dev[31:16] = 16'h0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("post_rst_rvalid", 32'(bus_rvalid), 32'd0);
    checkLatency("in0_after_rst", 4'h0, 16'h0000, 16'h0F0F);
    tick();
    checkOutput("no_stale_rvalid", 32'(bus_rvalid), 32'd0);
    busRead("status_after_rst", 4'h8, 16'h0001);
    busRead("mask_after_rst", 4'h9, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
